// File: rtl/riscy_pkg.sv
// Shared types and encodings for the RISC-V decode stage.
package riscy_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned PC_W_MAX = 64;

    typedef enum logic [3:0] {
        ILLEGAL = 4'd0, ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MULDIV
    } op_class_t;

    typedef enum logic [4:0] {
        ADD = 5'd0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } alu_op_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Carried at maximum width; the stage truncates pc/imm to its parameters.
    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        op_class_t           op_class;
        alu_op_t             alu_op;
        logic [2:0]          br_cond;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                rs1_valid;
        logic                rs2_valid;
        logic                rd_we;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } decoded_t;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return XLEN_MAX'($signed(v));
    endfunction

    function automatic alu_op_t base_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return alt ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) ();
    import riscy_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    op_class_t       out_op_class;
    alu_op_t         out_alu_op;
    logic [2:0]      out_br_cond;
    logic [1:0]      out_mem_size;
    logic            out_mem_unsigned;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_rs1_valid;
    logic            out_rs2_valid;
    logic            out_rd_we;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op_class, out_alu_op, out_br_cond,
               out_mem_size, out_mem_unsigned, out_rs1, out_rs2, out_rd,
               out_rs1_valid, out_rs2_valid, out_rd_we, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op_class, out_alu_op, out_br_cond,
               out_mem_size, out_mem_unsigned, out_rs1, out_rs2, out_rd,
               out_rs1_valid, out_rs2_valid, out_rd_we, out_imm, out_illegal
    );

endinterface

// File: rtl/decode_stage_comb.sv
// Combinational RV32I instruction decoder; M-extension decode enabled by RISCY_RV32M_EN.
module decode_comb
    import riscy_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output decoded_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shamt_ok;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // RV32 shifts only have a 5-bit shamt, so instr[25] must be clear there
    assign shamt_ok = (XLEN == 64) || !instr[25];

    always_comb begin
        dec          = '0;
        dec.pc       = PC_W_MAX'(pc);
        dec.op_class = ILLEGAL;
        dec.alu_op   = ADD;
        case (opc)
            OPC_LOAD: if (f3[1:0] != 2'b11 && f3 != 3'b110) begin
                dec.op_class     = LOAD;
                dec.mem_size     = f3[1:0];
                dec.mem_unsigned = f3[2];
                dec.imm          = sext32(imm_i);
            end
            OPC_STORE: if (!f3[2] && f3[1:0] != 2'b11) begin
                dec.op_class = STORE;
                dec.mem_size = f3[1:0];
                dec.imm      = sext32(imm_s);
            end
            OPC_BRANCH: if (f3[2:1] != 2'b01) begin
                dec.op_class = BRANCH;
                dec.br_cond  = f3;
                dec.imm      = sext32(imm_b);
            end
            OPC_JAL: begin
                dec.op_class = JAL;
                dec.imm      = sext32(imm_j);
            end
            OPC_JALR: if (f3 == 3'b000) begin
                dec.op_class = JALR;
                dec.imm      = sext32(imm_i);
            end
            OPC_OP_IMM: if ((f3 != 3'b001 && f3 != 3'b101) ||
                            (shamt_ok && (f7[6:1] == 6'b0 ||
                                          (f3 == 3'b101 && f7[6:1] == 6'b010000)))) begin
                dec.op_class = ALU_I;
                dec.alu_op   = base_alu_op(f3, f3 == 3'b101 && f7[5]);
                dec.imm      = sext32(imm_i);
            end
            OPC_OP: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.op_class = ALU_R;
                    dec.alu_op   = base_alu_op(f3, f7[5]);
                end else if (f7 == F7_MULDIV) begin
`ifdef RISCY_RV32M_EN
                    dec.op_class = MULDIV;
                    dec.alu_op   = alu_op_t'(5'(MUL) + 5'(f3));
`endif
                end
            end
            OPC_LUI: begin
                dec.op_class = LUI;
                dec.imm      = sext32(imm_u);
            end
            OPC_AUIPC: begin
                dec.op_class = AUIPC;
                dec.imm      = sext32(imm_u);
            end
            default: ;
        endcase

        dec.illegal = (dec.op_class == ILLEGAL);
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        if (!dec.illegal) begin
            dec.rd_we     = (dec.rd != 5'd0) && !(dec.op_class inside {STORE, BRANCH});
            dec.rs1_valid = !(dec.op_class inside {LUI, AUIPC, JAL});
            dec.rs2_valid = dec.op_class inside {ALU_R, STORE, BRANCH, MULDIV};
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry behind valid/ready handshakes.
module decode_stage
    import riscy_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    decoded_t dec, out_q, out_d, skid_q, skid_d;
    logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
    logic     in_xfer, out_xfer;

    decode_comb #(.XLEN(XLEN), .PC_W(PC_W)) u_decode_comb (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .dec   (dec)
    );

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    // Skid only fills while the output is held, so an empty output never sees a valid skid
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer || !out_valid_q) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_pc           = PC_W'(out_q.pc);
    assign bus.out_op_class     = out_q.op_class;
    assign bus.out_alu_op       = out_q.alu_op;
    assign bus.out_br_cond      = out_q.br_cond;
    assign bus.out_mem_size     = out_q.mem_size;
    assign bus.out_mem_unsigned = out_q.mem_unsigned;
    assign bus.out_rs1          = out_q.rs1;
    assign bus.out_rs2          = out_q.rs2;
    assign bus.out_rd           = out_q.rd;
    assign bus.out_rs1_valid    = out_q.rs1_valid;
    assign bus.out_rs2_valid    = out_q.rs2_valid;
    assign bus.out_rd_we        = out_q.rd_we;
    assign bus.out_imm          = XLEN'(out_q.imm);
    assign bus.out_illegal      = out_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised RISC-V instruction decode stage with valid/ready handshake on both sides and a 2-entry skid buffer.
- Input: fetched instruction plus PC from fetch.
- Output: a compact decoded bundle (operation class, ALU/branch/memory sub-op, register indices with valid flags, immediate) to execute.
- New relative to the previous single-cycle decoder: illegal-instruction detection, x0-write suppression, flush, backpressure, XLEN generalisation, optional M-extension decode.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 and 64. The immediate is sign-extended to XLEN. Shamt width is 5 for XLEN=32 and 6 for XLEN=64.
- PC_W, 32, width of the carried PC.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries; takes effect at the clock edge.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  PC_W  PC of the bundle.
- out_op_class  out  4  riscy_pkg::op_class_t: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MULDIV, ILLEGAL.
- out_alu_op  out  5  riscy_pkg::alu_op_t: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- out_br_cond  out  3  funct3 of the branch; 0 for non-branches.
- out_mem_size  out  2  0=byte, 1=half, 2=word.
- out_mem_unsigned  out  1  set for LBU/LHU.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rs1_valid, out_rs2_valid, out_rd_we  out  1 each  operand-use and write-enable flags.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  instruction not decodable.

Behaviour:
- Reset: out_valid=0, skid_valid=0, in_ready=1. All payload registers are cleared to 0, with out_op_class=ILLEGAL encoding 0.
- Transfers: input transfer = in_valid&&in_ready; output transfer = out_valid&&out_ready.
- Latency: one cycle from an accepted instruction to out_valid, when the output register is empty or being drained that cycle.
- Skid buffer:
  - in_ready = !skid_valid, driven from a register, with no combinational path from out_ready.
  - Accepting while the output register is held (out_valid&&!out_ready) writes the skid entry.
  - On an output transfer, the skid entry (if any) moves to the output register; otherwise the newly accepted instruction does.
  - Order is always preserved. Full throughput is one instruction per cycle with out_ready=1.
- Flush: clears out_valid and skid_valid at the edge. A simultaneous input transfer is discarded; a simultaneous output transfer still completes from execute's view. Reset takes priority over flush.
- Decode (combinational, before registering), on opcode[6:0]:
  - opcode[1:0]!=2'b11, an unknown opcode, or an unsupported funct3/funct7 sets illegal=1, op_class=ILLEGAL, rd_we=0 and both rsX_valid=0.
  - Shift-immediate with shamt[5]=1 when XLEN=32 is illegal.
  - RV64-only opcodes are illegal for both XLEN values.
- Immediates: I/S/B/U/J formats per the ISA, sign-extended from bit 31 to XLEN. U-type is {instr[31:12],12'b0}, sign-extended when XLEN=64.
- Operand flags:
  - rd_we=0 when rd==0, or for STORE/BRANCH.
  - rs1_valid=0 for LUI/AUIPC/JAL.
  - rs2_valid=1 only for ALU_R/STORE/BRANCH/MULDIV.
- LOAD funct3 011/110/111 is illegal. STORE funct3 >2 is illegal. BRANCH funct3 010/011 is illegal.
- FENCE/SYSTEM opcodes are ILLEGAL in this generation.

Optional Feature:
- Macro RISCY_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes to op_class=MULDIV, with alu_op selected by funct3 (MUL..REMU), rs1/rs2 valid and rd_we per the x0 rule.
- Undefined: that encoding is ILLEGAL, and the MULDIV/MUL..REMU enum values remain reserved in the package.

Decomposition:
- Package riscy_pkg holds:
  - op_class_t and alu_op_t enums.
  - opcode constants (OPC_LOAD=7'b0000011 etc.).
  - funct7 constants.
  - the packed struct decoded_t {pc, op_class, alu_op, br_cond, mem_size, mem_unsigned, rs1, rs2, rd, rs1_valid, rs2_valid, rd_we, imm, illegal}.
- Sub-module decode_comb (purely combinational instr->decoded_t, parametrised by XLEN). decode_stage instantiates it once and owns the output/skid registers and handshake.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: op_class=ALU_I, alu_op=ADD, rd=1, rd_we=1, rs1=0, rs1_valid=1, imm=5.
- 0x402081B3 (sub x3,x1,x2) -> op_class=ALU_R, alu_op=SUB, rs1=1, rs2=2, rd=3, rs2_valid=1.
- 0xFE208CE3 (beq x1,x2,-8), XLEN=64 -> op_class=BRANCH, br_cond=0, rd_we=0, imm=0xFFFFFFFFFFFFFFF8.
- 0x00000000 and 0x00000013 -> first: illegal=1, rd_we=0. Second (addi x0,x0,0): legal, rd_we=0.
- Back-to-back A,B,C with out_ready=0 for 3 cycles -> in_ready falls after B is accepted; then out_ready=1 yields A,B,C in order, no loss or duplication. A flush asserted with C in flight -> out_valid=0 next cycle and C is never output.
- 0x027302B3 (mul x5,x6,x7) -> with RISCY_RV32M_EN: op_class=MULDIV, alu_op=MUL, rd=5. Without the macro: illegal=1.
